// File: rtl/priority_req_serializer.sv
// Holds one request word and drains it as a stream of grant indices, highest set bit first.
// An all-zero word still produces a single framed beat flagged with out_empty.
module priority_req_serializer #(
   parameter int WIDTH = 128,
   parameter int IDXW  = 7,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   output logic             out_empty,
   output logic [CNTW-1:0]  pend_cnt,
   input  logic             flush
);

   typedef enum logic {IDLE, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  req_q, req_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              empty_q, empty_d;
   logic [IDXW-1:0]   hi_idx;

   function automatic logic [CNTW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [CNTW-1:0] s;
      s = '0;
      for (int i = 0; i < WIDTH; i++) s = s + CNTW'(v[i]);
      return s;
   endfunction

   // Ascending scan, so the last hit is the highest set bit (same order as the encoder).
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (req_q[i]) hi_idx = IDXW'(i);
   end

   // Outputs depend on registered state only.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DRAIN);
      out_idx   = (state_q == DRAIN && !empty_q) ? hi_idx : '0;
      out_last  = (state_q == DRAIN) && (cnt_q <= CNTW'(1));
      out_empty = (state_q == DRAIN) && empty_q;
      pend_cnt  = cnt_q;
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      empty_d = empty_q;
      if (flush) begin
         state_d = IDLE;
         req_d   = '0;
         cnt_d   = '0;
         empty_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  req_d   = in_req;
                  cnt_d   = popcnt(in_req);
                  empty_d = (in_req == '0);
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  req_d[out_idx] = 1'b0;
                  cnt_d = (cnt_q != '0) ? cnt_q - CNTW'(1) : '0;
                  if (out_last) begin
                     state_d = IDLE;
                     empty_d = 1'b0;
                     cnt_d   = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
      end
   end

endmodule

// File: tb/tb_priority_req_serializer.sv
// Bench for priority_req_serializer: vector table, hand-written corner sequences and
// randomized words checked against a queue-based reference of expected grants.
module tb_priority_req_serializer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready;
   logic [127:0] in_req;
   logic         out_valid, out_ready;
   logic [6:0]   out_idx;
   logic         out_last, out_empty;
   logic [7:0]   pend_cnt;
   logic         flush;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   priority_req_serializer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_last(out_last), .out_empty(out_empty),
      .pend_cnt(pend_cnt), .flush(flush)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge; returns at the negedge where the first beat is visible.
   task automatic send_word(input logic [127:0] req);
      int g = 0;
      while (!in_ready && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("send_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_req   = req;
      @(negedge clk);
      in_valid = 1'b0;
      in_req   = rand128();
   endtask

   // Reference: the grants are the set bits in descending order, one per accepted beat.
   task automatic drain_check(input string nm, input logic [127:0] req, input bit rand_rdy);
      int  q[$];
      bit  emp, done;
      int  g, e_idx, e_cnt;
      bit  e_last;
      for (int i = 127; i >= 0; i--) if (req[i]) q.push_back(i);
      emp  = (q.size() == 0);
      done = 1'b0;
      g    = 0;
      send_word(req);
      while (!done) begin
         e_idx  = emp ? 0 : q[0];
         e_cnt  = q.size();
         e_last = emp || (q.size() == 1);
         chk(nm, {46'd0, out_valid, out_empty, out_last, pend_cnt, out_idx},
                 {46'd0, 1'b1, emp, e_last, 8'(e_cnt), 7'(e_idx)});
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (out_ready) begin
            if (emp) done = 1'b1;
            else begin
               void'(q.pop_front());
               if (q.size() == 0) done = 1'b1;
            end
         end
         g++;
         if (g > 2000) begin
            chk({nm, "_timeout"}, 64'd1, 64'd0);
            done = 1'b1;
         end
      end
      out_ready = 1'b0;
      chk({nm, "_idle"}, {54'd0, in_ready, out_valid, pend_cnt}, {54'd0, 1'b1, 1'b0, 8'd0});
   endtask

   typedef struct {
      logic [127:0] req;
      int           first_idx;
      int           first_cnt;
      int           beats;
      int           last_idx;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [127:0] w;
      int rdy_pat[5]  = '{0, 1, 0, 0, 1};
      int exp_idx[5]  = '{3, 3, 2, 2, 2};
      int exp_cnt[5]  = '{2, 2, 1, 1, 1};
      int exp_last[5] = '{0, 0, 1, 1, 1};

      w = '0; w[5] = 1'b1; w[64] = 1'b1; w[127] = 1'b1;
      tbl[0] = '{w, 127, 3, 3, 5};
      tbl[1] = '{128'd0, 0, 0, 1, 0};
      tbl[2] = '{{128{1'b1}}, 127, 128, 128, 0};
      tbl[3] = '{128'd1, 0, 1, 1, 0};
      tbl[4] = '{128'hC, 3, 2, 2, 2};
      w = '0; w[100] = 1'b1;
      tbl[5] = '{w, 100, 1, 1, 100};

      rst_n = 1'b0; in_valid = 1'b0; in_req = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out", {46'd0, in_ready, out_valid, out_idx, out_last, out_empty, pend_cnt},
                       {46'd0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 8'd0});
      rst_n = 1'b1;
      @(negedge clk);

      // Table: full-rate drain, summarised per word.
      foreach (tbl[k]) begin
         int  beats, f_idx, f_cnt, l_idx, g;
         bit  seen;
         beats = 0; f_idx = -1; f_cnt = -1; l_idx = -1; seen = 1'b0; g = 0;
         send_word(tbl[k].req);
         out_ready = 1'b1;
         while (!seen && g < 400) begin
            if (out_valid) begin
               if (beats == 0) begin
                  f_idx = int'(out_idx);
                  f_cnt = int'(pend_cnt);
               end
               beats++;
               if (out_last) begin
                  l_idx = int'(out_idx);
                  seen  = 1'b1;
               end
            end
            @(negedge clk);
            g++;
         end
         out_ready = 1'b0;
         chk($sformatf("tbl%0d_first_idx", k), 64'(f_idx), 64'(tbl[k].first_idx));
         chk($sformatf("tbl%0d_first_cnt", k), 64'(f_cnt), 64'(tbl[k].first_cnt));
         chk($sformatf("tbl%0d_beats", k), 64'(beats), 64'(tbl[k].beats));
         chk($sformatf("tbl%0d_last_idx", k), 64'(l_idx), 64'(tbl[k].last_idx));
         chk($sformatf("tbl%0d_idle", k), {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
      end

      // Beat-by-beat against the reference for the directed words.
      drain_check("bits_127_64_5", tbl[0].req, 1'b0);
      drain_check("empty_word", 128'd0, 1'b0);
      drain_check("all_ones", {128{1'b1}}, 1'b0);

      // Stall pattern: the index must hold across stalls.
      send_word(128'hC);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_beat%0d", i), {47'd0, out_valid, out_last, pend_cnt, out_idx},
             {47'd0, 1'b1, 1'(exp_last[i]), 8'(exp_cnt[i]), 7'(exp_idx[i])});
         out_ready = 1'(rdy_pat[i]);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("stall_idle", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

      // Flush on the second beat of {10,9,8}.
      send_word(128'h700);
      out_ready = 1'b1;
      chk("flush_beat1", {56'd0, 1'b0, out_idx}, {56'd0, 1'b0, 7'd10});
      @(negedge clk);
      chk("flush_beat2", {56'd0, 1'b0, out_idx}, {56'd0, 1'b0, 7'd9});
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b0;
      chk("flush_idle", {54'd0, in_ready, out_valid, pend_cnt}, {54'd0, 1'b1, 1'b0, 8'd0});
      drain_check("after_flush", 128'd2, 1'b0);

      // Flush in IDLE discards an offered word.
      in_valid = 1'b1; in_req = 128'hFF; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_idle_discard", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

      // Asynchronous reset mid-drain of a 50-bit word.
      send_word({78'd0, {50{1'b1}}});
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", {54'd0, in_ready, out_valid, pend_cnt}, {54'd0, 1'b1, 1'b0, 8'd0});
      out_ready = 1'b0;
      @(negedge clk);
      chk("async_rst_hold", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
      rst_n = 1'b1;
      @(negedge clk);
      drain_check("post_reset", 128'h8000_0000_0000_0000_0000_0001_0000_0010, 1'b0);

      // Randomized words of varying density with random back-pressure.
      for (int r = 0; r < 24; r++) begin
         case ($urandom_range(0, 4))
            0: w = '0;
            1: w = rand128() & rand128() & rand128();
            2: w = rand128();
            3: w = rand128() | rand128();
            default: w = 128'd1 << $urandom_range(0, 127);
         endcase
         drain_check($sformatf("rand%0d", r), w, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
